aud_sram_ctrl: RTL

Top-level sequencer for the audio record/playback path. Turns debounced key pulses into start/pause/stop pulses for the recorder and the player. Owns the single SRAM port and muxes it between recorder writes and player reads. Tracks the recorded length so playback ends at the last written sample, and auto-stops recording when memory is full.

---
 rtl/aud_pkg.sv | 17 +
 rtl/aud_sram_mux.sv | 57 +++++
 rtl/aud_sram_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared audio-path definitions: controller state encoding and default bus widths.
// Used by the controller, recorder, player and display blocks.
package aud_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   // Encoding is also the value shown on the display
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REC        = 3'd1,
      S_REC_PAUSE  = 3'd2,
      S_PLAY       = 3'd3,
      S_PLAY_PAUSE = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/aud_sram_mux.sv
// Combinational SRAM port decode: strobes, address and write data selected
// purely from the controller state.
module aud_sram_mux
   import aud_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  ctrl_state_t       state,
   input  logic [ADDR_W-1:0] rec_addr,
   input  logic [DATA_W-1:0] rec_data,
   input  logic [ADDR_W-1:0] play_addr,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_wdata_oe,
   output logic              sram_ce_n,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n
);

   // Both byte lanes are always enabled: every access is a full 16-bit sample
   assign sram_lb_n = 1'b0;
   assign sram_ub_n = 1'b0;

   always_comb begin
      sram_addr     = '0;
      sram_wdata    = '0;
      sram_wdata_oe = 1'b0;
      sram_ce_n     = 1'b1;
      sram_we_n     = 1'b1;
      sram_oe_n     = 1'b1;
      unique case (state)
         S_REC: begin
            sram_ce_n     = 1'b0;
            sram_we_n     = 1'b0;
            sram_wdata_oe = 1'b1;
            sram_addr     = rec_addr;
            sram_wdata    = rec_data;
         end
         S_REC_PAUSE: begin
            // Chip stays selected but the DQ bus is released
            sram_ce_n  = 1'b0;
            sram_addr  = rec_addr;
            sram_wdata = rec_data;
         end
         S_PLAY, S_PLAY_PAUSE: begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
            sram_addr = play_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/aud_sram_ctrl.sv
// Record/playback sequencer: key pulses to recorder/player control pulses,
// recorded-length tracking and ownership of the shared SRAM port.
module aud_sram_ctrl
   import aud_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_key_start,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic              i_mode_rec,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [DATA_W-1:0] i_rec_data,
   output logic              o_play_start,
   output logic              o_play_pause,
   output logic              o_play_stop,
   input  logic [ADDR_W-1:0] i_play_addr,
   output logic [DATA_W-1:0] o_play_data,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_wdata,
   output logic              o_sram_wdata_oe,
   input  logic [DATA_W-1:0] i_sram_rdata,
   output logic              o_sram_ce_n,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_lb_n,
   output logic              o_sram_ub_n,
   output logic [ADDR_W-1:0] o_rec_len,
   output logic [2:0]        o_state
);

   ctrl_state_t       state_q, state_d;
   logic [ADDR_W-1:0] rec_len_q, rec_len_d;
   logic              rec_start_q, rec_start_d;
   logic              rec_pause_q, rec_pause_d;
   logic              rec_stop_q, rec_stop_d;
   logic              play_start_q, play_start_d;
   logic              play_pause_q, play_pause_d;
   logic              play_stop_q, play_stop_d;

   // Each branch takes exactly one transition, so at most one pulse is set
   always_comb begin
      state_d      = state_q;
      rec_len_d    = rec_len_q;
      rec_start_d  = 1'b0;
      rec_pause_d  = 1'b0;
      rec_stop_d   = 1'b0;
      play_start_d = 1'b0;
      play_pause_d = 1'b0;
      play_stop_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!i_key_stop && !i_key_pause && i_key_start) begin
               if (i_mode_rec) begin
                  state_d     = S_REC;
                  rec_start_d = 1'b1;
               end else if (rec_len_q != '0) begin
                  state_d      = S_PLAY;
                  play_start_d = 1'b1;
               end
            end
         end
         S_REC: begin
            if (i_rec_addr == MAX_ADDR) begin
               state_d    = S_IDLE;
               rec_stop_d = 1'b1;
               rec_len_d  = MAX_ADDR;
            end else if (i_key_stop) begin
               state_d    = S_IDLE;
               rec_stop_d = 1'b1;
               rec_len_d  = i_rec_addr;
            end else if (i_key_pause) begin
               state_d     = S_REC_PAUSE;
               rec_pause_d = 1'b1;
            end
         end
         S_REC_PAUSE: begin
            if (i_key_stop) begin
               state_d    = S_IDLE;
               rec_stop_d = 1'b1;
               rec_len_d  = i_rec_addr;
            end else if (!i_key_pause && i_key_start) begin
               state_d     = S_REC;
               rec_start_d = 1'b1;
            end
         end
         S_PLAY: begin
            if (i_play_addr >= rec_len_q || i_key_stop) begin
               state_d     = S_IDLE;
               play_stop_d = 1'b1;
            end else if (i_key_pause) begin
               state_d      = S_PLAY_PAUSE;
               play_pause_d = 1'b1;
            end
         end
         S_PLAY_PAUSE: begin
            if (i_key_stop) begin
               state_d     = S_IDLE;
               play_stop_d = 1'b1;
            end else if (!i_key_pause && i_key_start) begin
               state_d      = S_PLAY;
               play_start_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         rec_len_q    <= '0;
         rec_start_q  <= 1'b0;
         rec_pause_q  <= 1'b0;
         rec_stop_q   <= 1'b0;
         play_start_q <= 1'b0;
         play_pause_q <= 1'b0;
         play_stop_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rec_len_q    <= rec_len_d;
         rec_start_q  <= rec_start_d;
         rec_pause_q  <= rec_pause_d;
         rec_stop_q   <= rec_stop_d;
         play_start_q <= play_start_d;
         play_pause_q <= play_pause_d;
         play_stop_q  <= play_stop_d;
      end
   end

   assign o_rec_start  = rec_start_q;
   assign o_rec_pause  = rec_pause_q;
   assign o_rec_stop   = rec_stop_q;
   assign o_play_start = play_start_q;
   assign o_play_pause = play_pause_q;
   assign o_play_stop  = play_stop_q;
   assign o_rec_len    = rec_len_q;
   assign o_state      = state_q;
   assign o_play_data  = i_sram_rdata;

   aud_sram_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_sram_mux (
      .state         (state_q),
      .rec_addr      (i_rec_addr),
      .rec_data      (i_rec_data),
      .play_addr     (i_play_addr),
      .sram_addr     (o_sram_addr),
      .sram_wdata    (o_sram_wdata),
      .sram_wdata_oe (o_sram_wdata_oe),
      .sram_ce_n     (o_sram_ce_n),
      .sram_we_n     (o_sram_we_n),
      .sram_oe_n     (o_sram_oe_n),
      .sram_lb_n     (o_sram_lb_n),
      .sram_ub_n     (o_sram_ub_n)
   );

endmodule
